// File: rtl/frac_divider_if.sv
// Divisor control/status bundle for frac_divider: N/mf in, count/q_out (and tc
// when FRAC_DIV_TC_EN is defined) out.
interface frac_divider_if #(
  parameter int CNT_W = 17
) ();
  logic [CNT_W-1:0] N;
  logic [CNT_W-1:0] mf;
  logic [CNT_W-1:0] count;
  logic             q_out;
`ifdef FRAC_DIV_TC_EN
  logic             tc;

  modport master (output N, mf, input count, q_out, tc);
  modport slave  (input N, mf, output count, q_out, tc);
`else
  modport master (output N, mf, input count, q_out);
  modport slave  (input N, mf, output count, q_out);
`endif
endinterface

// File: rtl/frac_divider.sv
// Fractional clock divider: average period N + mf/2^FRAC_W clocks using a
// fractional residue accumulator. Define FRAC_DIV_TC_EN to add the tc output.
module frac_divider #(
  parameter int CNT_W  = 17,
  parameter int FRAC_W = 4
) (
  input  logic           sys_clk,
  input  logic           rst,
  frac_divider_if.slave  bus
);

  localparam int W = CNT_W + FRAC_W + 2;
  localparam logic signed [W-1:0] S_MIN = W'(2 << FRAC_W);
  localparam logic [CNT_W-1:0]    P_MAX = '1;

  logic [CNT_W-1:0]    count_r, p_r, p_nxt, cnt_inc;
  logic [FRAC_W-1:0]   acc_r, acc_nxt;
  logic                q_r, load;
  logic signed [W-1:0] t_val, s_val;

  // P==0 is the post-reset "load pending" marker.
  assign load    = (p_r == '0) || (count_r == p_r - CNT_W'(1));
  assign cnt_inc = count_r + CNT_W'(1);

  always_comb begin
    t_val   = {2'b00, bus.N, {FRAC_W{1'b0}}} + {{(FRAC_W+2){bus.mf[CNT_W-1]}}, bus.mf};
    s_val   = t_val + {{(CNT_W+2){1'b0}}, acc_r};
    p_nxt   = s_val[FRAC_W +: CNT_W];
    acc_nxt = s_val[FRAC_W-1:0];
    if (s_val < S_MIN) begin
      p_nxt   = CNT_W'(2);
      acc_nxt = '0;
    end else if (s_val[W-1:FRAC_W+CNT_W] != '0) begin
      p_nxt   = P_MAX;
      acc_nxt = '0;
    end
  end

  // q_out tracks count < P/2 one-for-one with count; on load it is always 1 since P>=2.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
      p_r     <= '0;
      acc_r   <= '0;
      q_r     <= 1'b0;
    end else if (load) begin
      count_r <= '0;
      p_r     <= p_nxt;
      acc_r   <= acc_nxt;
      q_r     <= 1'b1;
    end else begin
      count_r <= cnt_inc;
      q_r     <= cnt_inc < (p_r >> 1);
    end
  end

  assign bus.count = count_r;
  assign bus.q_out = q_r;

`ifdef FRAC_DIV_TC_EN
  logic tc_r;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)       tc_r <= 1'b0;
    else if (load) tc_r <= 1'b0;
    else           tc_r <= cnt_inc == p_r - CNT_W'(1);
  end

  assign bus.tc = tc_r;
`endif

endmodule

// File: tb/tb_frac_divider.sv
// Directed bench for frac_divider: period sequences, clamps, mid-period input
// changes and asynchronous reset, on a default and a narrow instance.
module tb_frac_divider;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  int vectors    = 0;
  int miscompares = 0;
  localparam int LIM = 2000;

  always #5 sys_clk = ~sys_clk;

  frac_divider_if #(.CNT_W(17)) bus ();
  frac_divider_if #(.CNT_W(6))  bus_s ();

  frac_divider #(.CNT_W(17), .FRAC_W(4)) dut   (.sys_clk(sys_clk), .rst(rst), .bus(bus));
  frac_divider #(.CNT_W(6),  .FRAC_W(4)) dut_s (.sys_clk(sys_clk), .rst(rst), .bus(bus_s));

  function automatic logic q_of(bit s);
    return s ? bus_s.q_out : bus.q_out;
  endfunction

  task automatic wait_rise(input bit s);
    logic p;
    p = q_of(s);
    for (int i = 0; i < LIM; i++) begin
      @(negedge sys_clk);
      if (!p && q_of(s)) return;
      p = q_of(s);
    end
    vectors++; miscompares++;
    $display("FAIL wait_rise: no q_out rise within %0d clocks", LIM);
  endtask

  // Counts clocks from the current negedge until the next q_out rise.
  task automatic get_period(input bit s, output int per, output int hi);
    logic p;
    per = 1;
    hi  = q_of(s) ? 1 : 0;
    p   = q_of(s);
    for (int i = 0; i < LIM; i++) begin
      @(negedge sys_clk);
      if (!p && q_of(s)) return;
      per++;
      if (q_of(s)) hi++;
      p = q_of(s);
    end
    vectors++; miscompares++;
    $display("FAIL get_period: no q_out rise within %0d clocks", LIM);
  endtask

  task automatic do_reset(input int n, input int m);
    @(negedge sys_clk);
    rst = 1'b1;
    bus.N  = 17'(n);
    bus.mf = 17'(m);
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge sys_clk);
    rst = 1'b1;
    bus.N = 17'd10; bus.mf = '0;
    @(negedge sys_clk);
    vectors++;
    if (bus.count !== 17'd0 || bus.q_out !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d q_out=%b, want 0/0", bus.count, bus.q_out);
    end
`ifdef FRAC_DIV_TC_EN
    vectors++;
    if (bus.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_tc: tc=%b, want 0", bus.tc);
    end
`endif
    rst = 1'b0;
    @(negedge sys_clk);
    vectors++;
    if (bus.count !== 17'd0 || bus.q_out !== 1'b1) begin
      miscompares++;
      $display("FAIL first_rise: count=%0d q_out=%b, want 0/1", bus.count, bus.q_out);
    end
  endtask

  task automatic test_basic();
    int e;
    do_reset(10, 0);
    for (int k = 0; k < 30; k++) begin
      @(negedge sys_clk);
      e = k % 10;
      vectors++;
      if (bus.count !== 17'(e) || bus.q_out !== (e < 5)) begin
        miscompares++;
        $display("FAIL basic_k%0d: count=%0d q_out=%b, want %0d/%b", k, bus.count, bus.q_out, e, e < 5);
      end
`ifdef FRAC_DIV_TC_EN
      vectors++;
      if (bus.tc !== (e == 9)) begin
        miscompares++;
        $display("FAIL basic_tc_k%0d: tc=%b, want %b", k, bus.tc, e == 9);
      end
`endif
    end
  endtask

  task automatic test_half();
    int per, hi, sum;
    do_reset(10, 8);
    wait_rise(1'b0);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      get_period(1'b0, per, hi);
      sum += per;
      vectors++;
      if (per != ((i % 2 == 0) ? 10 : 11)) begin
        miscompares++;
        $display("FAIL half_p%0d: period=%0d, want %0d", i, per, (i % 2 == 0) ? 10 : 11);
      end
    end
    vectors++;
    if (sum != 168) begin
      miscompares++;
      $display("FAIL half_sum: total=%0d, want 168", sum);
    end
  endtask

  task automatic test_neg();
    int per, hi, sum;
    int exp_p[4] = '{9, 10, 10, 9};
    do_reset(10, -5);
    wait_rise(1'b0);
    sum = 0;
    for (int i = 0; i < 16; i++) begin
      get_period(1'b0, per, hi);
      sum += per;
      if (i < 4) begin
        vectors++;
        if (per != exp_p[i] || hi != exp_p[i] / 2) begin
          miscompares++;
          $display("FAIL neg_p%0d: period=%0d high=%0d, want %0d/%0d", i, per, hi, exp_p[i], exp_p[i] / 2);
        end
      end
    end
    vectors++;
    if (sum != 155) begin
      miscompares++;
      $display("FAIL neg_sum: total=%0d, want 155", sum);
    end
  endtask

  task automatic test_clamp_low();
    int per, hi;
    do_reset(0, 0);
    wait_rise(1'b0);
    for (int i = 0; i < 4; i++) begin
      get_period(1'b0, per, hi);
      vectors++;
      if (per != 2 || hi != 1) begin
        miscompares++;
        $display("FAIL clamp0_p%0d: period=%0d high=%0d, want 2/1", i, per, hi);
      end
    end
    bus.N = 17'd1; bus.mf = 17'(-20);
    get_period(1'b0, per, hi);
    for (int i = 0; i < 4; i++) begin
      get_period(1'b0, per, hi);
      vectors++;
      if (per != 2 || hi != 1) begin
        miscompares++;
        $display("FAIL clampneg_p%0d: period=%0d high=%0d, want 2/1", i, per, hi);
      end
    end
    // A clamped load leaves no residue, so N=10 must give exactly 10.
    bus.N = 17'd10; bus.mf = '0;
    get_period(1'b0, per, hi);
    for (int i = 0; i < 3; i++) begin
      get_period(1'b0, per, hi);
      vectors++;
      if (per != 10) begin
        miscompares++;
        $display("FAIL clamp_acc_p%0d: period=%0d, want 10", i, per);
      end
    end
  endtask

  task automatic test_sat();
    int per, hi;
    bus_s.N = 6'd63; bus_s.mf = 6'd16;
    do_reset(10, 0);
    wait_rise(1'b1);
    for (int i = 0; i < 3; i++) begin
      get_period(1'b1, per, hi);
      vectors++;
      if (per != 63 || hi != 31) begin
        miscompares++;
        $display("FAIL sat_p%0d: period=%0d high=%0d, want 63/31", i, per, hi);
      end
    end
  endtask

  task automatic test_midchange();
    int per, hi, sum;
    do_reset(10, 0);
    wait_rise(1'b0);
    get_period(1'b0, per, hi);
    repeat (3) @(negedge sys_clk);
    bus.N = 17'd13;
    get_period(1'b0, per, hi);
    vectors++;
    if (per != 7) begin
      miscompares++;
      $display("FAIL mid_rem: remaining=%0d, want 7", per);
    end
    get_period(1'b0, per, hi);
    vectors++;
    if (per != 13 || hi != 6) begin
      miscompares++;
      $display("FAIL mid_new: period=%0d high=%0d, want 13/6", per, hi);
    end
    for (int k = -5; k <= 14; k++) begin
      repeat (2) @(negedge sys_clk);
      bus.N = 17'd10; bus.mf = 17'(k);
      get_period(1'b0, per, hi);
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        get_period(1'b0, per, hi);
        sum += per;
      end
      vectors++;
      if (sum != 160 + k) begin
        miscompares++;
        $display("FAIL step_mf%0d: total=%0d, want %0d", k, sum, 160 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    int per, hi;
    bit hit;
    do_reset(100, 12);
    wait_rise(1'b0);
    get_period(1'b0, per, hi);
    hit = 1'b0;
    for (int i = 0; i < LIM && !hit; i++) begin
      @(negedge sys_clk);
      hit = (bus.count == 17'd37);
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL rstmid_reach: count never reached 37");
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (bus.count !== 17'd0 || bus.q_out !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_async: count=%0d q_out=%b, want 0/0", bus.count, bus.q_out);
    end
`ifdef FRAC_DIV_TC_EN
    vectors++;
    if (bus.tc !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_tc: tc=%b, want 0", bus.tc);
    end
`endif
    repeat (2) @(negedge sys_clk);
    rst = 1'b0;
    wait_rise(1'b0);
    get_period(1'b0, per, hi);
    vectors++;
    if (per != 100 || hi != 50) begin
      miscompares++;
      $display("FAIL rstmid_p0: period=%0d high=%0d, want 100/50", per, hi);
    end
    get_period(1'b0, per, hi);
    vectors++;
    if (per != 101) begin
      miscompares++;
      $display("FAIL rstmid_p1: period=%0d, want 101", per);
    end
  endtask

  initial begin
    bus.N = '0; bus.mf = '0;
    bus_s.N = 6'd4; bus_s.mf = '0;
    test_reset();
    test_basic();
    test_half();
    test_neg();
    test_clamp_low();
    test_sat();
    test_midchange();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/frac_divider.md
Name: frac_divider

Overview:
- Fractional clock divider. Divides sys_clk by an average ratio of N + mf/2^FRAC_W. mf is signed, in sixteenths by default.
- Each output period is an integer number of clocks, either floor or ceil of the ratio. A fractional phase accumulator spreads the error so the long-run average is exact.
- Sits between the system clock and any block that needs a low-rate, finely trimmable timebase, e.g. 50 MHz / 68750.3125.

Parameters:
- CNT_W, 17, width of N, mf, count and the internal period register.
- FRAC_W, 4, number of fractional bits in mf; resolution is 1/2^FRAC_W clock.

Ports:
- sys_clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- N  in  CNT_W  unsigned integer divisor.
- mf  in  CNT_W  signed two's-complement fractional trim in units of 1/2^FRAC_W clock; may be negative.
- count  out  CNT_W  instantaneous position within the current output period, 0..P-1.
- q_out  out  1  divided clock output.

Behaviour:
- Registers:
  - count (CNT_W)
  - P (CNT_W), current period length
  - acc (FRAC_W), fractional residue
  - q_out
- Reset (asynchronous, rst=1): count=0, P=0, acc=0, q_out=0. P=0 means "load pending".
- Load condition: P==0, or count==P-1 (terminal count). On a load clock:
  - Form T = (N << FRAC_W) + sign_extend(mf), signed, width CNT_W+FRAC_W+2.
  - Form S = T + acc.
  - If S < 2<<FRAC_W: P<=2, acc<=0.
  - Else if (S>>FRAC_W) > 2^CNT_W-1: P<=2^CNT_W-1, acc<=0.
  - Otherwise: P<=S>>FRAC_W, acc<=S[FRAC_W-1:0].
  - count<=0.
- Non-load clock: count<=count+1; P and acc hold.
- N and mf are sampled only on load clocks. A change mid-period takes effect at the next period; there is no glitch or truncation.
- q_out is registered and equals 1 exactly when count < (P>>1) for the current P.
  - It becomes 1 on the clock count loads 0.
  - For odd P, the low phase is one cycle longer than the high phase.
- Exactly one rising edge of q_out per period. The first rising edge is on the first clock after rst deasserts.
- Average period over 2^FRAC_W consecutive periods with constant inputs (no saturation) = exactly T clocks in total / 2^FRAC_W per period.
- Minimum period is 2, so q_out always toggles. Maximum period is 2^CNT_W-1.
- Reset mid-period aborts immediately. Outputs return to reset values asynchronously.

Optional Feature:
- Macro FRAC_DIV_TC_EN.
- Defined: adds output port tc (1 bit, registered), high for exactly one clock when count==P-1, i.e. the clock preceding each load. tc resets to 0 and is 0 while P==0.
- Undefined: no tc port; all other behaviour is identical.

Test Plan:
- Reset then N=10, mf=0: periods all 10 clocks; q_out high 5, low 5; count cycles 0..9; first q_out rise one clock after rst release.
- N=10, mf=8: periods alternate 10, 11, 10, 11 (acc 8, 0, 8, 0); 16 consecutive periods total 168 clocks.
- N=10, mf=-5: period sequence starts 9, 10, 10, 9 (acc 11, 6, 1, 12); any 16 consecutive periods total 155 clocks; odd periods give high 4, low 5.
- N=0, mf=0, then N=1, mf=-20: period clamps to 2 (q_out toggles every clock), acc stays 0; N=131071, mf=15: period clamps to 131071.
- N=68750, mf stepped -5..14 (step +1 every 24 ms of 50 MHz time, changes asserted mid-period): each new mf is applied only from the following period; sum of 16 periods = 1100000+mf.
- Assert rst mid-period with count=37: count, P, acc, q_out go to 0 without waiting for a clock edge; normal operation resumes on release. With FRAC_DIV_TC_EN defined, tc pulses once per period on count==P-1.
